// File: rtl/rf_pkg.sv
// Shared constants and helpers for the multi-port register file.
package rf_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 16;

   // Address width that never collapses to zero bits, even for a 1-entry array.
   function automatic int clog2_safe(input int n);
      int r;
      r = 0;
      for (int v = 1; v < n; v = v * 2) begin
         r = r + 1;
      end
      if (r == 0) begin
         r = 1;
      end
      return r;
   endfunction

   typedef logic [XLEN_DEF-1:0] word_t;

endpackage

// File: rtl/rf_write_arb.sv
// Per-address write resolution across all write ports; the highest-numbered port wins a collision.
module rf_write_arb
   import rf_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int NREGS  = NREGS_DEF,
   parameter int NWRITE = 1,
   parameter int AW     = clog2_safe(NREGS_DEF)
) (
   input  logic [NWRITE-1:0]      i_wr_en,
   input  logic [NWRITE*AW-1:0]   i_wr_addr,
   input  logic [NWRITE*XLEN-1:0] i_wr_data,
   output logic [NREGS-1:0]       o_hit,
   output logic [XLEN-1:0]        o_data [NREGS]
);

   always_comb begin
      o_hit = '0;
      for (int a = 0; a < NREGS; a++) begin
         o_data[a] = '0;
      end
      // Ascending scan so a later port overwrites an earlier one on the same address.
      for (int j = 0; j < NWRITE; j++) begin
         if (i_wr_en[j] && (i_wr_addr[j*AW +: AW] != '0)) begin
            o_hit[i_wr_addr[j*AW +: AW]]  = 1'b1;
            o_data[i_wr_addr[j*AW +: AW]] = i_wr_data[j*XLEN +: XLEN];
         end
      end
   end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with same-cycle write bypass and a per-register busy scoreboard.
module regfile_mp_sb
   import rf_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int NREGS  = NREGS_DEF,
   parameter int NREAD  = 2,
   parameter int NWRITE = 1,
   parameter int BYPASS = 1
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [NREAD*clog2_safe(NREGS)-1:0]     rd_addr,
   output logic [NREAD*XLEN-1:0]                  rd_data,
   output logic [NREAD-1:0]                       rd_busy,
   input  logic [NWRITE-1:0]                      wr_en,
   input  logic [NWRITE*clog2_safe(NREGS)-1:0]    wr_addr,
   input  logic [NWRITE*XLEN-1:0]                 wr_data,
   input  logic                                   rsv_en,
   input  logic [clog2_safe(NREGS)-1:0]           rsv_addr,
   input  logic                                   flush
);

   localparam int AW = clog2_safe(NREGS);

   logic [XLEN-1:0]  r_regs [NREGS];
   logic [NREGS-1:0] r_busy;

   logic [NREGS-1:0] w_hit;
   logic [XLEN-1:0]  w_wdata [NREGS];

   rf_write_arb #(
      .XLEN   (XLEN),
      .NREGS  (NREGS),
      .NWRITE (NWRITE),
      .AW     (AW)
   ) u_arb (
      .i_wr_en   (wr_en),
      .i_wr_addr (wr_addr),
      .i_wr_data (wr_data),
      .o_hit     (w_hit),
      .o_data    (w_wdata)
   );

   // Register 0 is only ever cleared; the arbiter never reports a hit on it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int a = 0; a < NREGS; a++) begin
            r_regs[a] <= '0;
         end
      end else begin
         for (int a = 1; a < NREGS; a++) begin
            if (w_hit[a]) begin
               r_regs[a] <= w_wdata[a];
            end
         end
      end
   end

   // Flush beats a reservation, which beats a writeback clearing the bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_busy <= '0;
      end else if (flush) begin
         r_busy <= '0;
      end else begin
         for (int a = 1; a < NREGS; a++) begin
            if (rsv_en && (rsv_addr == AW'(a))) begin
               r_busy[a] <= 1'b1;
            end else if (w_hit[a]) begin
               r_busy[a] <= 1'b0;
            end
         end
      end
   end

   for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
      logic [AW-1:0] w_addr;
      logic          w_byp;
      logic          w_zero;

      assign w_addr = rd_addr[gi*AW +: AW];
      assign w_byp  = (BYPASS != 0) && w_hit[w_addr];
      // Reset gates the outputs so a write presented during reset cannot leak through the bypass.
      assign w_zero = reset || (w_addr == '0);

      assign rd_data[gi*XLEN +: XLEN] = w_zero ? '0 :
                                        w_byp  ? w_wdata[w_addr] : r_regs[w_addr];
      assign rd_busy[gi]              = (w_zero || w_byp) ? 1'b0 : r_busy[w_addr];
   end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench: a 2-write-port bypassing file and a 1-write-port non-bypassing file side by side.
module tb_regfile_mp_sb;

   logic clk;
   logic reset;

   logic [7:0]  a_rd_addr;
   logic [63:0] a_rd_data;
   logic [1:0]  a_rd_busy;
   logic [1:0]  a_wr_en;
   logic [7:0]  a_wr_addr;
   logic [63:0] a_wr_data;
   logic        a_rsv_en;
   logic [3:0]  a_rsv_addr;
   logic        a_flush;

   logic [7:0]  b_rd_addr;
   logic [63:0] b_rd_data;
   logic [1:0]  b_rd_busy;
   logic [0:0]  b_wr_en;
   logic [3:0]  b_wr_addr;
   logic [31:0] b_wr_data;
   logic        b_rsv_en;
   logic [3:0]  b_rsv_addr;
   logic        b_flush;

   int n_vec;
   int n_bad;

   regfile_mp_sb #(.XLEN(32), .NREGS(16), .NREAD(2), .NWRITE(2), .BYPASS(1)) u_dut_a (
      .clk      (clk),
      .reset    (reset),
      .rd_addr  (a_rd_addr),
      .rd_data  (a_rd_data),
      .rd_busy  (a_rd_busy),
      .wr_en    (a_wr_en),
      .wr_addr  (a_wr_addr),
      .wr_data  (a_wr_data),
      .rsv_en   (a_rsv_en),
      .rsv_addr (a_rsv_addr),
      .flush    (a_flush)
   );

   regfile_mp_sb #(.XLEN(32), .NREGS(16), .NREAD(2), .NWRITE(1), .BYPASS(0)) u_dut_b (
      .clk      (clk),
      .reset    (reset),
      .rd_addr  (b_rd_addr),
      .rd_data  (b_rd_data),
      .rd_busy  (b_rd_busy),
      .wr_en    (b_wr_en),
      .wr_addr  (b_wr_addr),
      .wr_data  (b_wr_data),
      .rsv_en   (b_rsv_en),
      .rsv_addr (b_rsv_addr),
      .flush    (b_flush)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic idle();
      a_wr_en  = '0;
      a_rsv_en = 1'b0;
      a_flush  = 1'b0;
      b_wr_en  = '0;
      b_rsv_en = 1'b0;
      b_flush  = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic a_wr(input int p, input logic [3:0] ad, input logic [31:0] d);
      a_wr_en[p]           = 1'b1;
      a_wr_addr[p*4 +: 4]  = ad;
      a_wr_data[p*32 +: 32] = d;
   endtask

   task automatic a_rd(input logic [3:0] ad0, input logic [3:0] ad1);
      a_rd_addr = {ad1, ad0};
   endtask

   initial begin
      n_vec      = 0;
      n_bad      = 0;
      reset      = 1'b1;
      a_rd_addr  = '0;
      a_wr_addr  = '0;
      a_wr_data  = '0;
      a_rsv_addr = '0;
      b_rd_addr  = '0;
      b_wr_addr  = '0;
      b_wr_data  = '0;
      b_rsv_addr = '0;
      idle();
      repeat (2) @(posedge clk);
      #1;
      a_rd(4'd5, 4'd9);
      #1;
      chk("reset_rd0", {32'h0, a_rd_data[31:0]}, 64'h0);
      chk("reset_busy", {62'h0, a_rd_busy}, 64'h0);
      reset = 1'b0;

      // Load DEADBEEF and a reservation, then yank reset mid-cycle.
      a_wr(0, 4'd1, 32'hDEADBEEF);
      a_wr(1, 4'd2, 32'hDEADBEEF);
      a_rsv_en   = 1'b1;
      a_rsv_addr = 4'd2;
      step();
      idle();
      a_rd(4'd1, 4'd2);
      #1;
      chk("pre_rst_data", a_rd_data, {32'hDEADBEEF, 32'hDEADBEEF});
      chk("pre_rst_busy", {62'h0, a_rd_busy}, 64'h2);
      #1 reset = 1'b1;
      #1;
      chk("async_rst_data", a_rd_data, 64'h0);
      chk("async_rst_busy", {62'h0, a_rd_busy}, 64'h0);
      step();
      reset = 1'b0;
      #1;
      chk("post_rst_r1", a_rd_data, 64'h0);

      // Plain write then read next cycle; writes to r0 are dropped.
      a_wr(0, 4'd5, 32'h12345678);
      b_wr_en   = 1'b1;
      b_wr_addr = 4'd5;
      b_wr_data = 32'h12345678;
      step();
      idle();
      a_rd(4'd5, 4'd0);
      b_rd_addr = {4'd0, 4'd5};
      #1;
      chk("wr_r5_a", {32'h0, a_rd_data[31:0]}, 64'h12345678);
      chk("wr_r5_b", {32'h0, b_rd_data[31:0]}, 64'h12345678);
      a_wr(0, 4'd0, 32'hFFFFFFFF);
      #1;
      chk("r0_bypass", {32'h0, a_rd_data[63:32]}, 64'h0);
      step();
      idle();
      a_rd(4'd0, 4'd0);
      #1;
      chk("r0_stored", {32'h0, a_rd_data[31:0]}, 64'h0);
      chk("r0_busy", {62'h0, a_rd_busy}, 64'h0);

      // Bypass: reserve r3 first so the bypass also has to mask a live busy bit.
      a_rsv_en   = 1'b1;
      a_rsv_addr = 4'd3;
      step();
      idle();
      a_rd(4'd5, 4'd3);
      #1;
      chk("r3_busy_set", {62'h0, a_rd_busy}, 64'h2);
      a_wr(0, 4'd3, 32'hA5A5A5A5);
      b_wr_en   = 1'b1;
      b_wr_addr = 4'd3;
      b_wr_data = 32'hA5A5A5A5;
      b_rd_addr = {4'd3, 4'd5};
      #1;
      chk("byp_data", {32'h0, a_rd_data[63:32]}, 64'hA5A5A5A5);
      chk("byp_busy_mask", {62'h0, a_rd_busy}, 64'h0);
      chk("nobyp_old", {32'h0, b_rd_data[63:32]}, 64'h0);
      step();
      idle();
      #1;
      chk("byp_after", {32'h0, a_rd_data[63:32]}, 64'hA5A5A5A5);
      chk("r3_busy_clr", {62'h0, a_rd_busy}, 64'h0);
      chk("nobyp_new", {32'h0, b_rd_data[63:32]}, 64'hA5A5A5A5);

      // Two ports colliding on r7: port 1 wins, also through the bypass.
      a_wr(0, 4'd7, 32'h00000001);
      a_wr(1, 4'd7, 32'h00000002);
      a_rd(4'd7, 4'd0);
      #1;
      chk("collide_byp", {32'h0, a_rd_data[31:0]}, 64'h2);
      step();
      idle();
      #1;
      chk("collide_r7", {32'h0, a_rd_data[31:0]}, 64'h2);

      // Scoreboard: reserve, writeback, and reserve racing a writeback.
      a_rsv_en   = 1'b1;
      a_rsv_addr = 4'd4;
      a_rd(4'd4, 4'd0);
      #1;
      chk("rsv_not_comb", {62'h0, a_rd_busy}, 64'h0);
      step();
      idle();
      #1;
      chk("rsv_r4_busy", {62'h0, a_rd_busy}, 64'h1);
      a_wr(1, 4'd4, 32'h00000044);
      step();
      idle();
      #1;
      chk("wb_r4_busy", {62'h0, a_rd_busy}, 64'h0);
      chk("wb_r4_data", {32'h0, a_rd_data[31:0]}, 64'h44);
      a_wr(0, 4'd4, 32'h00000055);
      a_rsv_en   = 1'b1;
      a_rsv_addr = 4'd4;
      step();
      idle();
      #1;
      chk("rsv_wr_data", {32'h0, a_rd_data[31:0]}, 64'h55);
      chk("rsv_wr_busy", {62'h0, a_rd_busy}, 64'h1);
      a_rsv_en   = 1'b1;
      a_rsv_addr = 4'd0;
      step();
      idle();
      a_rd(4'd0, 4'd4);
      #1;
      chk("rsv_r0", {62'h0, a_rd_busy}, 64'h2);

      // Several reservations, then a flush that also swallows a reservation of r10.
      a_rsv_en = 1'b1;
      a_rsv_addr = 4'd2;
      step();
      a_rsv_addr = 4'd6;
      step();
      a_rsv_addr = 4'd9;
      step();
      idle();
      a_rd(4'd2, 4'd6);
      #1;
      chk("multi_busy_2_6", {62'h0, a_rd_busy}, 64'h3);
      a_rd(4'd9, 4'd1);
      #1;
      chk("multi_busy_9", {62'h0, a_rd_busy}, 64'h1);
      a_flush    = 1'b1;
      a_rsv_en   = 1'b1;
      a_rsv_addr = 4'd10;
      step();
      idle();
      a_rd(4'd2, 4'd6);
      #1;
      chk("flush_2_6", {62'h0, a_rd_busy}, 64'h0);
      a_rd(4'd9, 4'd10);
      #1;
      chk("flush_9_10", {62'h0, a_rd_busy}, 64'h0);
      a_rd(4'd4, 4'd5);
      #1;
      chk("flush_keeps_data", a_rd_data, {32'h12345678, 32'h00000055});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
